// File: rtl/pos_counter_if.sv
// Parent-facing control/readback bundle of one wheel position counter.
// The parent drives clear/subtract/distance and reads pos1/pos2.
interface pos_counter_if;
  logic [1:0]  clear;
  logic        subtract;
  logic [15:0] distance;
  logic [15:0] pos1;
  logic [15:0] pos2;

  modport master (
    output clear,
    output subtract,
    output distance,
    input  pos1,
    input  pos2
  );

  modport slave (
    input  clear,
    input  subtract,
    input  distance,
    output pos1,
    output pos2
  );
endinterface

// File: rtl/pos_counter.sv
// Encoder edge counter: trip count pos1 and rebasable distance count pos2.
// Define POSCOUNTER_SYNC_EN for the 2-flop synchronizer (latency 2, else 1).
module pos_counter (
  input  logic         clk,
  input  logic         reset,
  input  logic         sensor,
  pos_counter_if.slave bus
);

  logic        rise;
  logic [15:0] pos1_q;
  logic [15:0] pos2_q;

`ifdef POSCOUNTER_SYNC_EN
  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sensor;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
`else
  // sensor already synchronous to clk: s1 is the sample, s2 the history
  logic s1, s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sensor;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      pos1_q <= '0;
    else if (bus.clear[0])
      pos1_q <= '0;
    else if (rise)
      pos1_q <= pos1_q + 16'd1;
  end

  // a rebase in an edge cycle still counts the edge
  always_ff @(posedge clk) begin
    if (reset)
      pos2_q <= '0;
    else if (bus.clear[1])
      pos2_q <= '0;
    else if (bus.subtract)
      pos2_q <= pos2_q - bus.distance + {15'd0, rise};
    else if (rise)
      pos2_q <= pos2_q + 16'd1;
  end

  assign bus.pos1 = pos1_q;
  assign bus.pos2 = pos2_q;

endmodule

// File: tb/tb_pos_counter.sv
// Bench for pos_counter: operation table plus scoreboard queue of expected
// counter values, and a hand-written edge-latency sequence.
module tb_pos_counter;

`ifdef POSCOUNTER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  logic sensor;

  pos_counter_if bus ();

  pos_counter dut (
    .clk    (clk),
    .reset  (reset),
    .sensor (sensor),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef enum int {
    OP_RESET, OP_CLEAR, OP_PULSE, OP_SUB, OP_SUBR,
    OP_CLRR, OP_CLRSUB, OP_LEVEL, OP_FLIGHT, OP_RSTFL
  } op_e;

  typedef struct {
    string       name;
    op_e         op;
    logic [15:0] arg;
    logic [15:0] e1;
    logic [15:0] e2;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] e1;
    logic [15:0] e2;
  } exp_t;

  localparam int NV = 24;
  vec_t tbl [NV];
  exp_t sb [$];

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sensor = 1'b1;
      tick();
      sensor = 1'b0;
      tick();
    end
    tick();
    tick();
  endtask

  // rise reaches the counters on edge E1+LAT; present c/s/d on that edge
  task automatic rise_with(input logic [1:0] c, input logic s,
                           input logic [15:0] d);
    sensor = 1'b1;
    tick();
    sensor = 1'b0;
    repeat (LAT - 1) tick();
    bus.clear    = c;
    bus.subtract = s;
    bus.distance = d;
    tick();
    bus.clear    = 2'b00;
    bus.subtract = 1'b0;
    bus.distance = 16'd0;
    tick();
    tick();
  endtask

  task automatic apply(input vec_t v);
    case (v.op)
      OP_RESET: begin
        reset = 1'b1; tick(); reset = 1'b0; tick();
      end
      OP_CLEAR: begin
        bus.clear = v.arg[1:0]; tick(); bus.clear = 2'b00; tick();
      end
      OP_PULSE: pulses(int'(v.arg));
      OP_SUB: begin
        bus.subtract = 1'b1;
        bus.distance = v.arg;
        tick();
        bus.subtract = 1'b0;
        bus.distance = 16'd0;
        tick();
      end
      OP_SUBR: rise_with(2'b00, 1'b1, v.arg);
      OP_CLRR: rise_with(v.arg[1:0], 1'b0, 16'd0);
      OP_CLRSUB: begin
        bus.clear    = 2'b10;
        bus.subtract = 1'b1;
        bus.distance = v.arg;
        tick();
        bus.clear    = 2'b00;
        bus.subtract = 1'b0;
        bus.distance = 16'd0;
        tick();
      end
      OP_LEVEL: begin
        sensor = 1'b1;
        repeat (5) tick();
        sensor = 1'b0;
        tick(); tick(); tick();
      end
      OP_FLIGHT: begin
        bus.clear = 2'b01;
        sensor    = 1'b1;
        tick();
        bus.clear = 2'b00;
        sensor    = 1'b0;
        tick(); tick(); tick();
      end
      OP_RSTFL: begin
        sensor = 1'b1;
        tick();
        sensor = 1'b0;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        tick(); tick(); tick();
      end
      default: ;
    endcase
  endtask

  initial begin
    tbl[0]  = '{"reset",      OP_RESET,  16'd0,     16'd0, 16'h0000};
    tbl[1]  = '{"clear01",    OP_CLEAR,  16'd1,     16'd0, 16'h0000};
    tbl[2]  = '{"pulse3",     OP_PULSE,  16'd3,     16'd3, 16'h0003};
    tbl[3]  = '{"pulse16",    OP_PULSE,  16'd16,    16'd19, 16'h0013};
    tbl[4]  = '{"sel_clr1",   OP_CLEAR,  16'd1,     16'd0, 16'h0013};
    tbl[5]  = '{"sel_clr2",   OP_CLEAR,  16'd2,     16'd0, 16'h0000};
    tbl[6]  = '{"pulse5",     OP_PULSE,  16'd5,     16'd5, 16'h0005};
    tbl[7]  = '{"sub8000",    OP_SUB,    16'h8000,  16'd5, 16'h8005};
    tbl[8]  = '{"sub_rise",   OP_SUBR,   16'h8000,  16'd6, 16'h0006};
    tbl[9]  = '{"pulse2",     OP_PULSE,  16'd2,     16'd8, 16'h0008};
    tbl[10] = '{"rebase0",    OP_SUB,    16'd8,     16'd8, 16'h0000};
    tbl[11] = '{"sub_wrap",   OP_SUB,    16'd1,     16'd8, 16'hFFFF};
    tbl[12] = '{"inc_wrap",   OP_PULSE,  16'd1,     16'd9, 16'h0000};
    tbl[13] = '{"level",      OP_LEVEL,  16'd0,     16'd10, 16'h0001};
    tbl[14] = '{"clr11_rise", OP_CLRR,   16'd3,     16'd0, 16'h0000};
    tbl[15] = '{"pulse4",     OP_PULSE,  16'd4,     16'd4, 16'h0004};
    tbl[16] = '{"clr01_rise", OP_CLRR,   16'd1,     16'd0, 16'h0005};
    tbl[17] = '{"clr10_rise", OP_CLRR,   16'd2,     16'd1, 16'h0000};
    tbl[18] = '{"pulse2b",    OP_PULSE,  16'd2,     16'd3, 16'h0002};
    tbl[19] = '{"clr_sub",    OP_CLRSUB, 16'd3,     16'd3, 16'h0000};
    tbl[20] = '{"inflight",   OP_FLIGHT, 16'd0,     16'd1, 16'h0001};
    tbl[21] = '{"pulse6",     OP_PULSE,  16'd6,     16'd7, 16'h0007};
    tbl[22] = '{"rst_flight", OP_RSTFL,  16'd0,     16'd0, 16'h0000};
    tbl[23] = '{"pulse7",     OP_PULSE,  16'd7,     16'd7, 16'h0007};

    reset        = 1'b1;
    sensor       = 1'b0;
    bus.clear    = 2'b00;
    bus.subtract = 1'b0;
    bus.distance = 16'd0;
    tick();
    reset = 1'b0;
    chk("reset_pos1", bus.pos1, 16'd0);
    chk("reset_pos2", bus.pos2, 16'd0);

    for (int i = 0; i < NV; i++) begin
      sb.push_back('{tbl[i].name, tbl[i].e1, tbl[i].e2});
      apply(tbl[i]);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s scoreboard empty", tbl[i].name);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_pos1"}, bus.pos1, e.e1);
        chk({e.name, "_pos2"}, bus.pos2, e.e2);
      end
    end

    // edge latency: count 7 -> 8 lands exactly LAT edges after sampling
    sensor = 1'b1;
    tick();
    sensor = 1'b0;
    chk("lat_e1", bus.pos1, 16'd7);
    repeat (LAT - 1) begin
      tick();
      chk("lat_early", bus.pos1, 16'd7);
    end
    tick();
    chk("lat_pos1", bus.pos1, 16'd8);
    chk("lat_pos2", bus.pos2, 16'd8);
    tick();
    tick();
    chk("lat_hold", bus.pos1, 16'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
